sd_iofull_n: RTL and testbench
==============================

Name: sd_iofull_n

Overview:
- Parametrised successor to the 2-entry fully-registered srdy/drdy closure buffer.
- Generalised to `depth` entries, with a registered occupancy count and an almost-full flag.
- Breaks every timing path across a pipeline boundary: c_drdy, p_srdy, p_data, usage and afull are all driven directly from flops.
- Sustains one transfer per cycle, so long pipelines can be closed and credit-style backpressure absorbed without bubbles.

Parameters:
- width, 8, data bits per beat.
- depth, 4, number of storage entries; legal range >= 2. Elaboration error if < 2.
- afull_thresh, depth-1, afull asserts when occupancy >= this value; legal range 1..depth.
- ctrl_fanout, 64, maximum data bits driven by one replicated load/select control flop. Replication count = ceil(width/ctrl_fanout).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- c_srdy  input  1  upstream data valid.
- c_drdy  output  1  ready to accept; flop output.
- c_data  input  width  upstream data.
- p_srdy  output  1  downstream data valid; flop output.
- p_drdy  input  1  downstream ready.
- p_data  output  width  downstream data; flop output, no combinational path from c_data.
- usage  output  $clog2(depth+1)  entries held; flop output.
- afull  output  1  usage >= afull_thresh; flop output.

Behaviour:
- Transfer definitions:
  - push = c_srdy & c_drdy.
  - pop = p_srdy & p_drdy.
  - Without push, c_data is ignored.
  - When p_srdy=1, p_data is the oldest unpopped entry.
- Occupancy:
  - cnt_nxt = usage + push - pop.
  - cnt_nxt never exceeds depth and never underflows.
- Registered flags, loaded every cycle from cnt_nxt:
  - c_drdy <= (cnt_nxt < depth).
  - p_srdy <= (cnt_nxt > 0).
  - afull <= (cnt_nxt >= afull_thresh).
  - usage <= cnt_nxt.
- Ordering: strict FIFO, no reordering, duplication or loss.
- Latency: a beat pushed at edge N is presented on p_data/p_srdy after edge N (visible in cycle N+1) if the buffer was empty. Otherwise it is presented after all older beats are popped.
- Throughput:
  - Simultaneous push and pop is legal in every state where both are enabled, giving 1 beat/cycle sustained.
  - When full, c_drdy=0. A pop at full re-asserts c_drdy in the next cycle, so at most a 1-cycle bubble occurs, and only at the full boundary.
- Storage: circular array with wr/rd pointers wrapping from depth-1 to 0 (depth need not be a power of 2).
- Head register:
  - p_data is a head register reloaded on pop with the next entry.
  - When the buffer is empty, or holds one entry that is being popped, a concurrent push loads c_data directly into the head register (bypass into the flop, not around it).
- Simultaneous events:
  - Push at full cannot occur, because c_drdy=0.
  - Push and pop with usage=1 leaves usage=1 and the head = new beat.
  - Pop with no push at usage=1 leads to usage=0 and p_srdy=0.
- Control fan-out: the load, shift and select controls for the data path are replicated per ctrl_fanout group, all copies identical. The last group takes the remainder bits.
- Reset:
  - Cycle after a reset edge: c_drdy=0, p_srdy=0, usage=0, afull=0 (afull_thresh>=1); pointers cleared.
  - Data storage and p_data are not reset; they are don't-care while p_srdy=0.
  - c_drdy rises on the first edge with reset=0.
  - Reset asserted mid-traffic discards all held entries in one cycle. c_srdy and p_drdy are ignored while reset=1.
- p_data must hold stable while p_srdy=1 and p_drdy=0.

Test Plan:
- Reset, then idle: hold reset 2 cycles, release -> c_drdy=0 in first released cycle, 1 thereafter; p_srdy=0, usage=0, afull=0.
- Fill and stall (depth=4, afull_thresh=3): push 0x11,0x22,0x33,0x44 with p_drdy=0 -> usage 1,2,3,4; afull=1 after the 3rd push; c_drdy=0 after the 4th; p_data=0x11 throughout.
- Drain from full: then p_drdy=1, c_srdy=0 -> p_data 0x11,0x22,0x33,0x44 on consecutive cycles; c_drdy=1 one cycle after the first pop; p_srdy=0 and usage=0 after the 4th pop.
- Streaming: c_srdy=p_drdy=1 for 100 cycles with incrementing data from empty -> 1 beat/cycle out, 1-cycle latency, usage steady at 1, no gaps, order preserved.
- Random backpressure (width=70, ctrl_fanout=32, depth=3): random c_srdy/p_drdy for 10k cycles -> scoreboard exact FIFO match across all 3 control groups; usage equals the model each cycle; p_data stable while stalled; pointer wrap exercised.
- Reset mid-operation: with usage=3, assert reset 1 cycle -> next cycle usage=0, p_srdy=0; subsequent pushes emerge with no stale data.

Source files
------------

// File: rtl/sd_iofull_n.sv
// sd_iofull_n: fully-registered srdy/drdy FIFO with head register, usage count and almost-full flag.
module sd_iofull_n #(
    parameter int width        = 8,
    parameter int depth        = 4,
    parameter int afull_thresh = depth - 1,
    parameter int ctrl_fanout  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       c_srdy,
    output logic                       c_drdy,
    input  logic [width-1:0]           c_data,
    output logic                       p_srdy,
    input  logic                       p_drdy,
    output logic [width-1:0]           p_data,
    output logic [$clog2(depth+1)-1:0] usage,
    output logic                       afull
);
    localparam int uw = $clog2(depth + 1);
    localparam int pw = $clog2(depth);
    localparam int ng = (width + ctrl_fanout - 1) / ctrl_fanout;

    if (depth < 2) begin : g_bad_depth
        $error("sd_iofull_n: depth must be >= 2");
    end
    if (afull_thresh < 1 || afull_thresh > depth) begin : g_bad_thresh
        $error("sd_iofull_n: afull_thresh must be in 1..depth");
    end

    function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
        return p == pw'(depth - 1) ? '0 : p + 1'b1;
    endfunction

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr, rd, wr_nxt, rd_nxt;
    logic [uw-1:0]    cnt_nxt;
    logic             push, pop;

    always_comb begin
        push    = c_srdy & c_drdy;
        pop     = p_srdy & p_drdy;
        cnt_nxt = usage + uw'(push) - uw'(pop);
        wr_nxt  = push ? inc(wr) : wr;
        rd_nxt  = pop ? inc(rd) : rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr     <= '0;
            rd     <= '0;
            usage  <= '0;
            c_drdy <= 1'b0;
            p_srdy <= 1'b0;
            afull  <= 1'b0;
        end else begin
            wr     <= wr_nxt;
            rd     <= rd_nxt;
            usage  <= cnt_nxt;
            c_drdy <= cnt_nxt < uw'(depth);
            p_srdy <= cnt_nxt != '0;
            afull  <= cnt_nxt >= uw'(afull_thresh);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr] <= c_data;

    // Each slice of the head register has its own copy of the next-read pointer
    // and the bypass select, so no single control flop drives more than ctrl_fanout bits.
    for (genvar g = 0; g < ng; g++) begin : g_grp
        localparam int lo = g * ctrl_fanout;
        localparam int hi = ((lo + ctrl_fanout > width) ? width : lo + ctrl_fanout) - 1;
        logic [pw-1:0]    rd1;
        logic             low, load;
        logic [hi:lo]     head;
        always_comb load = pop | (push & ~p_srdy);
        always_ff @(posedge clk) begin
            if (reset) begin
                rd1 <= pw'(1);
                low <= 1'b1;
            end else begin
                rd1 <= inc(rd_nxt);
                low <= cnt_nxt <= uw'(1);
            end
        end
        always_ff @(posedge clk)
            if (load) head <= low ? c_data[hi:lo] : mem[rd1][hi:lo];
        assign p_data[hi:lo] = head;
    end
endmodule

// File: tb/tb_sd_iofull_n.sv
// tb_sd_iofull_n: directed and scoreboard checks of sd_iofull_n in two configurations.
module tb_sd_iofull_n;
    logic        clk = 1'b0;
    logic        reset;
    logic        c_srdy, c_drdy, p_srdy, p_drdy, afull;
    logic [7:0]  c_data, p_data;
    logic [2:0]  usage;
    logic        c2_srdy, c2_drdy, p2_srdy, p2_drdy, afull2;
    logic [69:0] c2_data, p2_data;
    logic [1:0]  usage2;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sd_iofull_n #(.width(8), .depth(4), .afull_thresh(3)) dut (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .usage(usage), .afull(afull));

    sd_iofull_n #(.width(70), .depth(3), .ctrl_fanout(32)) dut2 (
        .clk(clk), .reset(reset), .c_srdy(c2_srdy), .c_drdy(c2_drdy), .c_data(c2_data),
        .p_srdy(p2_srdy), .p_drdy(p2_drdy), .p_data(p2_data), .usage(usage2), .afull(afull2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; c_srdy = 0; p_drdy = 0; c_data = '0;
        c2_srdy = 0; p2_drdy = 0; c2_data = '0;
        tick(); tick();
        n_checks++;
        if ({c_drdy, p_srdy, usage, afull} !== 6'b0) begin
            n_fail++; $display("FAIL reset_state: got drdy=%b srdy=%b usage=%0d afull=%b, need all 0", c_drdy, p_srdy, usage, afull);
        end
        reset = 1'b0;
        n_checks++;
        if (c_drdy !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_drdy: got %b need 0", c_drdy); end
        tick();
        n_checks++;
        if (c_drdy !== 1'b1 || p_srdy !== 1'b0 || usage !== 3'd0 || afull !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got drdy=%b srdy=%b usage=%0d afull=%b, need 1 0 0 0", c_drdy, p_srdy, usage, afull);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        p_drdy = 0;
        for (int i = 0; i < 4; i++) begin
            c_srdy = 1; c_data = vals[i];
            tick();
            c_srdy = 0;
            n_checks++;
            if (usage !== 3'(i + 1) || afull !== (i >= 2) || c_drdy !== (i < 3) || p_srdy !== 1'b1 || p_data !== 8'h11) begin
                n_fail++; $display("FAIL fill_%0d: got usage=%0d afull=%b drdy=%b srdy=%b data=%h, need %0d %b %b 1 11",
                                   i, usage, afull, c_drdy, p_srdy, p_data, i + 1, i >= 2, i < 3);
            end
        end
        c_srdy = 1; c_data = 8'h55;
        tick();
        c_srdy = 0;
        n_checks++;
        if (usage !== 3'd4 || p_data !== 8'h11 || c_drdy !== 1'b0) begin
            n_fail++; $display("FAIL push_at_full: got usage=%0d data=%h drdy=%b, need 4 11 0", usage, p_data, c_drdy);
        end
        p_drdy = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (p_srdy !== 1'b1 || p_data !== vals[i]) begin
                n_fail++; $display("FAIL drain_data_%0d: got srdy=%b data=%h, need 1 %h", i, p_srdy, p_data, vals[i]);
            end
            tick();
            n_checks++;
            if (usage !== 3'(3 - i) || c_drdy !== 1'b1) begin
                n_fail++; $display("FAIL drain_state_%0d: got usage=%0d drdy=%b, need %0d 1", i, usage, c_drdy, 3 - i);
            end
        end
        n_checks++;
        if (p_srdy !== 1'b0 || afull !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got srdy=%b afull=%b need 0 0", p_srdy, afull);
        end
        p_drdy = 0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        c_srdy = 1; p_drdy = 1;
        for (int i = 0; i < 100; i++) begin
            c_data = 8'(i);
            tick();
            n_checks++;
            if (usage !== 3'd1 || p_srdy !== 1'b1 || c_drdy !== 1'b1 || p_data !== 8'(i)) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL stream_%0d: got usage=%0d srdy=%b drdy=%b data=%h, need 1 1 1 %h", i, usage, p_srdy, c_drdy, p_data, 8'(i));
            end
        end
        c_srdy = 0;
        tick();
        p_drdy = 0;
        n_checks++;
        if (usage !== 3'd0 || p_srdy !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain: got usage=%0d srdy=%b need 0 0", usage, p_srdy);
        end
    endtask

    task automatic test_reset_mid();
        p_drdy = 0;
        for (int i = 0; i < 3; i++) begin
            c_srdy = 1; c_data = 8'hA0 + 8'(i);
            tick();
        end
        c_srdy = 0;
        n_checks++;
        if (usage !== 3'd3 || afull !== 1'b1) begin
            n_fail++; $display("FAIL mid_prefill: got usage=%0d afull=%b need 3 1", usage, afull);
        end
        reset = 1; c_srdy = 1; p_drdy = 1; c_data = 8'hEE;
        tick();
        n_checks++;
        if (usage !== 3'd0 || p_srdy !== 1'b0 || c_drdy !== 1'b0 || afull !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got usage=%0d srdy=%b drdy=%b afull=%b need 0 0 0 0", usage, p_srdy, c_drdy, afull);
        end
        reset = 0; c_srdy = 0; p_drdy = 0;
        tick();
        c_srdy = 1; c_data = 8'h5A;
        tick();
        c_srdy = 0;
        n_checks++;
        if (usage !== 3'd1 || p_srdy !== 1'b1 || p_data !== 8'h5A) begin
            n_fail++; $display("FAIL mid_after: got usage=%0d srdy=%b data=%h need 1 1 5a", usage, p_srdy, p_data);
        end
        p_drdy = 1;
        tick();
        p_drdy = 0;
        n_checks++;
        if (usage !== 3'd0 || p_srdy !== 1'b0) begin
            n_fail++; $display("FAIL mid_pop: got usage=%0d srdy=%b need 0 0", usage, p_srdy);
        end
    endtask

    task automatic test_random();
        logic [69:0] q [$];
        logic [69:0] prev_data = '0;
        logic [95:0] r;
        logic        prev_stall = 0, push, pop;
        int          bad = 0, fulls = 0;
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            c2_data = r[69:0];
            c2_srdy = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            p2_drdy = (i < 5000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            n_checks++;
            if (int'(usage2) != q.size() || p2_srdy !== (q.size() > 0) || c2_drdy !== (q.size() < 3) ||
                afull2 !== (q.size() >= 2) || (q.size() > 0 && p2_data !== q[0]) ||
                (prev_stall && p2_data !== prev_data)) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL random_%0d: got usage=%0d srdy=%b drdy=%b afull=%b data=%h, need usage=%0d head=%h",
                                      i, usage2, p2_srdy, c2_drdy, afull2, p2_data, q.size(), q.size() > 0 ? q[0] : 70'h0);
            end
            push = c2_srdy && q.size() < 3;
            pop = p2_drdy && q.size() > 0;
            prev_stall = q.size() > 0 && !p2_drdy;
            prev_data = p2_data;
            if (q.size() == 3) fulls++;
            tick();
            if (pop) void'(q.pop_front());
            if (push) q.push_back(c2_data);
        end
        c2_srdy = 0; p2_drdy = 0;
        n_checks++;
        if (fulls == 0) begin n_fail++; $display("FAIL random_coverage: got %0d full cycles need > 0", fulls); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
